vga_frame_buffer: RTL
=====================

# vga_frame_buffer

Bit-mapped frame buffer that sits directly upstream of the VGA timing generator and supplies its pixel colour input. The buffer holds 160x120 1-bit pixels (one cell per 4x4 screen block of the 640x480 display) in on-chip block RAM and maps each bit to a 12-bit foreground or background colour. The VGA timing generator's pixel address feeds the buffer's read side. A valid/ready write port and a whole-screen clear engine form the write side.

## Interface
Parameters:
- FB_W, 160, frame buffer width in cells
- FB_H, 120, frame buffer height in cells
- SCALE_SHIFT, 2, log2 of screen pixels per cell edge

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous active-low reset
- ADR_X  in  10  screen pixel X, 0..639 valid
- ADR_Y  in  9  screen pixel Y, 0..479 valid
- COLOUR  out  12  registered pixel colour; connects to the timing generator's colour input
- FG_COLOUR  in  12  colour for cell bit 1
- BG_COLOUR  in  12  colour for cell bit 0
- WR_VALID  in  1  write request
- WR_READY  out  1  registered; write accepted on WR_VALID and WR_READY
- WR_X  in  8  cell X
- WR_Y  in  7  cell Y
- WR_DATA  in  1  cell value
- WR_ERR  out  1  one-cycle pulse: an accepted write had an out-of-range coordinate
- CLEAR_REQ  in  1  start a clear; sampled in IDLE only
- CLEAR_VAL  in  1  fill value for the clear, latched with CLEAR_REQ
- BUSY  out  1  high while a clear is running

## Operation
- Cell index = cy*160 + cx. Compute it as (cy<<7)+(cy<<5)+cx, 15 bits. The maximum index is 19199.
- Read side: cx = ADR_X[9:2] and cy = ADR_Y[8:2].
  - The read is in range when ADR_X<640 and ADR_Y<480.
  - When out of range, COLOUR = BG_COLOUR.
- FSM states: CLEAR and IDLE.
  - Reset puts the FSM in CLEAR with fill value 0 and counter 0. Memory content is not reset; the initial clear defines it.
  - CLEAR: write fill value to index = counter, one write per cycle. When the counter reaches 19199, go to IDLE next cycle.
  - IDLE: CLEAR_REQ=1 latches CLEAR_VAL, zeroes the counter and moves the FSM to CLEAR.
- WR_READY is a register equal to (next state == IDLE).
  - An accepted write with WR_X<160 and WR_Y<120 writes the memory.
  - Otherwise the write is dropped, and WR_ERR pulses on the cycle after acceptance.
- Simultaneous WR_VALID and CLEAR_REQ in IDLE: the write is accepted and performed. The clear starts the next cycle and overwrites it.
- CLEAR_REQ while in CLEAR is ignored.
- A write held during CLEAR stalls (WR_READY=0). It completes on the first IDLE cycle.
- Memory read-during-write at the same index returns old data (read-first).

## Timing
- Reset values:
  - COLOUR=0, WR_READY=0, WR_ERR=0, BUSY=1
  - state=CLEAR, counter=0, fill value=0
- The initial clear takes 19200 cycles after RESET deasserts. WR_READY rises on cycle 19201.
- Read latency is 3 cycles, ADR_X/ADR_Y to COLOUR:
  - stage 1: index and in-range flag registered
  - stage 2: RAM read data and flag delayed
  - stage 3: colour mux registered
- FG_COLOUR/BG_COLOUR are sampled at stage 3.
- Write to visible latency is one cycle. A read of the written index issued on the accept cycle or later sees the new value.
- BUSY = (state == CLEAR), registered.
- RESET asserted mid-clear: all outputs return to reset values immediately. The clear restarts from counter 0 with fill value 0.

## Structure
- Shared package vga_pkg holds:
  - FB_W, FB_H, FB_DEPTH=19200, SCALE_SHIFT
  - COLOUR_W=12 and the screen limits 640/480
  - the FSM state encoding (CLEAR, IDLE)
- Sub-module frame_ram: simple dual-port 19200x1 block RAM.
  - Port A is a synchronous write.
  - Port B is a synchronous read-first read.
  - It has no reset.
- Top level contains the index arithmetic, FSM, clear counter, write handshake and read pipeline.

## Test plan
- Reset release: BUSY=1 for exactly 19200 cycles, then WR_READY=1 and BUSY=0. A sweep of all 640x480 ADR values returns BG_COLOUR=0x00F.
- Write (WR_X=10, WR_Y=20, WR_DATA=1) with FG=0xF00 and BG=0x00F:
  - ADR_X=40..43, ADR_Y=80..83 give COLOUR=0xF00 three cycles later.
  - ADR_X=44 or ADR_Y=84 gives 0x00F.
- Write with WR_X=160, WR_Y=0: accepted, WR_ERR=1 for one cycle. Cells (0,1) and (159,0) stay BG.
- CLEAR_REQ=1, CLEAR_VAL=1 in IDLE, with WR_VALID held for (5,5)=0:
  - BUSY=1 and WR_READY=0 for 19200 cycles.
  - Afterwards, (5,5) reads BG once the write completes; every other cell reads FG.
- RESET pulsed low at clear counter 5000 of a CLEAR_VAL=1 clear:
  - COLOUR=0, WR_READY=0 and BUSY=1 immediately.
  - A fresh 19200-cycle clear follows, and all cells read BG.
- Boundary reads:
  - ADR_X=639, ADR_Y=479 reads cell 19199. After writing (159,119)=1 it reads FG.
  - ADR_X=700, ADR_Y=479 gives BG regardless of memory.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, state encoding and cell-index helper for the VGA frame buffer.
package vga_pkg;

    localparam int FB_W        = 160;
    localparam int FB_H        = 120;
    localparam int FB_DEPTH    = 19200;
    localparam int SCALE_SHIFT = 2;
    localparam int COLOUR_W    = 12;
    localparam int SCR_W       = 640;
    localparam int SCR_H       = 480;
    localparam int IDX_W       = 15;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } fb_state_t;

    // cy*160 + cx using shifts and adds only
    function automatic logic [IDX_W-1:0] cell_index(input logic [7:0] cx, input logic [6:0] cy);
        logic [IDX_W-1:0] w_y;
        w_y = {8'b0, cy};
        return (w_y << 7) + (w_y << 5) + {7'b0, cx};
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port 1-bit block RAM: synchronous write on port A, registered
// read-first read on port B. No reset so it maps onto block RAM.
module frame_ram
    import vga_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int AW    = IDX_W
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic          i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic          o_rdata
);

    logic r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/vga_frame_buffer.sv
// 160x120 1-bit frame buffer feeding the VGA timing generator's colour input,
// with a valid/ready cell write port and a whole-screen clear engine.
module vga_frame_buffer
    import vga_pkg::*;
#(
    parameter int FB_W        = vga_pkg::FB_W,
    parameter int FB_H        = vga_pkg::FB_H,
    parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [9:0]          ADR_X,
    input  logic [8:0]          ADR_Y,
    output logic [COLOUR_W-1:0] COLOUR,
    input  logic [COLOUR_W-1:0] FG_COLOUR,
    input  logic [COLOUR_W-1:0] BG_COLOUR,
    input  logic                WR_VALID,
    output logic                WR_READY,
    input  logic [7:0]          WR_X,
    input  logic [6:0]          WR_Y,
    input  logic                WR_DATA,
    output logic                WR_ERR,
    input  logic                CLEAR_REQ,
    input  logic                CLEAR_VAL,
    output logic                BUSY
);

    fb_state_t        r_state, w_state_nxt;
    logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_fill, w_fill_nxt;

    logic [7:0]       w_rd_cx;
    logic [6:0]       w_rd_cy;
    logic             w_rd_inr;
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] r_rd_idx_p1;
    logic             r_rd_inr_p1, r_rd_inr_p2;
    logic             w_ram_rdata;

    logic             w_wr_acc, w_wr_inr;
    logic             w_ram_we;
    logic [IDX_W-1:0] w_ram_waddr;
    logic             w_ram_wdata;

    assign w_rd_cx  = 8'(ADR_X >> SCALE_SHIFT);
    assign w_rd_cy  = 7'(ADR_Y >> SCALE_SHIFT);
    assign w_rd_inr = (ADR_X < 10'(SCR_W)) && (ADR_Y < 9'(SCR_H));
    // Out-of-range reads are masked at the colour mux; park the RAM address at 0
    assign w_rd_idx = w_rd_inr ? cell_index(w_rd_cx, w_rd_cy) : '0;

    assign w_wr_acc = WR_VALID && WR_READY;
    assign w_wr_inr = (WR_X < 8'(FB_W)) && (WR_Y < 7'(FB_H));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fill_nxt  = r_fill;
        case (r_state)
            CLEAR: begin
                if (r_cnt == IDX_W'(FB_DEPTH - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (CLEAR_REQ) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                    w_fill_nxt  = CLEAR_VAL;
                end
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    // Clear engine owns the write port in CLEAR; host writes are only accepted in IDLE
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = r_cnt;
        w_ram_wdata = r_fill;
        if (r_state == CLEAR) begin
            w_ram_we = 1'b1;
        end else if (w_wr_acc && w_wr_inr) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = cell_index(WR_X, WR_Y);
            w_ram_wdata = WR_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= CLEAR;
            r_cnt    <= '0;
            r_fill   <= 1'b0;
            WR_READY <= 1'b0;
            BUSY     <= 1'b1;
            WR_ERR   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_fill   <= w_fill_nxt;
            WR_READY <= (w_state_nxt == IDLE);
            BUSY     <= (w_state_nxt == CLEAR);
            WR_ERR   <= w_wr_acc && !w_wr_inr;
        end
    end

    frame_ram #(
        .DEPTH (FB_DEPTH),
        .AW    (IDX_W)
    ) u_ram (
        .i_clk   (CLK),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (r_rd_idx_p1),
        .o_rdata (w_ram_rdata)
    );

    // Stage 1: index register
    always_ff @(posedge CLK) begin
        r_rd_idx_p1 <= w_rd_idx;
    end

    // Stage 1/2 range flag, stage 3 colour mux
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rd_inr_p1 <= 1'b0;
            r_rd_inr_p2 <= 1'b0;
            COLOUR      <= '0;
        end else begin
            r_rd_inr_p1 <= w_rd_inr;
            r_rd_inr_p2 <= r_rd_inr_p1;
            COLOUR      <= (r_rd_inr_p2 && w_ram_rdata) ? FG_COLOUR : BG_COLOUR;
        end
    end

endmodule
